unibus_arbiter: RTL and testbench

Central Unibus priority arbiter on the CPU side of the bus. Samples the BR7–BR4 and NPR request lines raised by peripherals such as the DL11, and grants one winner at a time on BG7–BG4/NPG, gated by the processor priority and the CPU's arbitration windows. Tracks each grant through SACK and BBSY release. Drops a grant that no device acknowledges within a timeout. Sits beside the CPU core and drives the grant end of every daisy chain.

---
 rtl/unibus_arbiter_pkg.sv | 6 +
 rtl/unibus_arbiter_sack_timer.sv | 15 +
 rtl/unibus_arbiter.sv | 86 ++++++++
 tb/tb_unibus_arbiter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/unibus_arbiter_pkg.sv
// unibus_arbiter_pkg: shared state encoding, NPR grant level code and default timeout
package unibus_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, ACKED} state_e;
  localparam logic [2:0] LVL_NPR = 3'd0;
  localparam int TIMEOUT_DEF = 500;
endpackage

// File: rtl/unibus_arbiter_sack_timer.sv
// sack_timer: saturating cycle counter with clear/enable; done at TIMEOUT-1
module sack_timer #(
  parameter int TIMEOUT = 500
) (
  input  logic clk,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (en_i && cnt_q != W'(TIMEOUT)) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= cnt_d;
  assign done_o = cnt_q == W'(TIMEOUT - 1);
endmodule

// File: rtl/unibus_arbiter.sv
// unibus_arbiter: fixed-priority NPR/BR7..BR4 grant FSM with SACK tracking and grant timeout
module unibus_arbiter
  import unibus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bus_init,
  input  logic [7:4] bus_br,
  input  logic       bus_npr,
  input  logic       bus_sack,
  input  logic       bus_bbsy,
  input  logic [2:0] cpu_prio,
  input  logic       cpu_br_window,
  input  logic       cpu_npr_window,
  output logic [7:4] bus_bg_out,
  output logic       bus_npg,
  output logic       cpu_hold,
  output logic [2:0] grant_level,
  output logic       no_sack
);
  state_e state_q, state_d;
  logic [7:4] bg_q, bg_d, br_ok, br_pick;
  logic [2:0] lvl_q, lvl_d, br_lvl;
  logic npg_q, npg_d, hold_q, no_sack_q, no_sack_d, npr_ok, done, clr;
  for (genvar n = 4; n < 8; n++) begin : g_br
    assign br_ok[n] = bus_br[n] & cpu_br_window & (3'(n) > cpu_prio);
  end
  assign npr_ok  = bus_npr & cpu_npr_window;
  assign br_pick = br_ok[7] ? 4'b1000 : br_ok[6] ? 4'b0100 : br_ok[5] ? 4'b0010 : br_ok[4] ? 4'b0001 : 4'b0000;
  assign br_lvl  = br_ok[7] ? 3'd7 : br_ok[6] ? 3'd6 : br_ok[5] ? 3'd5 : 3'd4;
  assign clr     = reset | bus_init | (state_q != GRANT);
  sack_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk   (clk),
    .clr_i (clr),
    .en_i  (state_q == GRANT),
    .done_o(done)
  );
  always_comb begin
    state_d   = state_q;
    bg_d      = bg_q;
    npg_d     = npg_q;
    lvl_d     = lvl_q;
    no_sack_d = 1'b0;
    if (reset || bus_init) begin
      state_d = IDLE;
      bg_d    = '0;
      npg_d   = 1'b0;
      lvl_d   = '0;
    end else if (state_q == IDLE) begin
      if (npr_ok) begin
        state_d = GRANT;
        npg_d   = 1'b1;
        lvl_d   = LVL_NPR;
      end else if (|br_ok) begin
        state_d = GRANT;
        bg_d    = br_pick;
        lvl_d   = br_lvl;
      end
    end else if (state_q == GRANT) begin
      // SACK on the timeout edge takes precedence over the timeout
      if (bus_sack || done) begin
        state_d   = bus_sack ? ACKED : IDLE;
        bg_d      = '0;
        npg_d     = 1'b0;
        no_sack_d = !bus_sack;
      end
    end else if (!bus_sack && !bus_bbsy) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    state_q   <= state_d;
    bg_q      <= bg_d;
    npg_q     <= npg_d;
    lvl_q     <= lvl_d;
    no_sack_q <= no_sack_d;
    hold_q    <= state_d != IDLE;
  end
  assign bus_bg_out  = bg_q;
  assign bus_npg     = npg_q;
  assign cpu_hold    = hold_q;
  assign grant_level = lvl_q;
  assign no_sack     = no_sack_q;
endmodule

// File: tb/tb_unibus_arbiter.sv
// tb_unibus_arbiter: directed vectors with hand-computed expectations for unibus_arbiter
module tb_unibus_arbiter;
  logic clk = 1'b0, reset, bus_init, bus_npr, bus_sack, bus_bbsy, cpu_br_window, cpu_npr_window;
  logic [7:4] bus_br, bus_bg_out;
  logic [2:0] cpu_prio, grant_level;
  logic bus_npg, cpu_hold, no_sack;
  int errors = 0, checks = 0, hi;
  always #5 clk = ~clk;
  unibus_arbiter dut (
    .clk(clk), .reset(reset), .bus_init(bus_init), .bus_br(bus_br), .bus_npr(bus_npr),
    .bus_sack(bus_sack), .bus_bbsy(bus_bbsy), .cpu_prio(cpu_prio), .cpu_br_window(cpu_br_window),
    .cpu_npr_window(cpu_npr_window), .bus_bg_out(bus_bg_out), .bus_npg(bus_npg), .cpu_hold(cpu_hold),
    .grant_level(grant_level), .no_sack(no_sack)
  );
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic release_bus();
    bus_sack = 1'b1;
    tick();
    chk("ack_bg", {bus_bg_out, 3'b0, bus_npg}, 8'h00);
    chk("ack_hold", 8'(cpu_hold), 8'd1);
    bus_sack = 1'b0; bus_br = '0; bus_npr = 1'b0;
    tick();
    chk("rel_hold", 8'(cpu_hold), 8'd0);
  endtask
  always @(negedge clk)
    if (!reset) chk("excl", 8'($countones({bus_bg_out, bus_npg}) <= 1), 8'd1);
  initial begin
    reset = 1'b1; bus_init = 1'b0; bus_br = '0; bus_npr = 1'b0; bus_sack = 1'b0; bus_bbsy = 1'b0;
    cpu_prio = 3'd0; cpu_br_window = 1'b0; cpu_npr_window = 1'b0;
    tick(2);
    chk("rst_out", {bus_bg_out, bus_npg, cpu_hold, no_sack, 1'b0}, 8'h00);
    chk("rst_lvl", 8'(grant_level), 8'd0);
    reset = 1'b0;
    bus_br = 4'b0100; cpu_prio = 3'd4; cpu_br_window = 1'b1;
    tick();
    chk("br6_bg", 8'(bus_bg_out), 8'h04);
    chk("br6_lvl", 8'(grant_level), 8'd6);
    chk("br6_hold", 8'(cpu_hold), 8'd1);
    tick(2);
    chk("br6_held", 8'(bus_bg_out), 8'h04);
    bus_sack = 1'b1;
    tick();
    chk("br6_drop", 8'(bus_bg_out), 8'h00);
    bus_sack = 1'b0; bus_bbsy = 1'b1; bus_br = '0;
    tick(3);
    chk("bbsy_hold", 8'(cpu_hold), 8'd1);
    bus_bbsy = 1'b0;
    tick();
    chk("bbsy_rel", 8'(cpu_hold), 8'd0);
    bus_npr = 1'b1; bus_br = 4'b1000; cpu_npr_window = 1'b1; cpu_prio = 3'd0;
    tick();
    chk("npr_g", {bus_bg_out, 3'b0, bus_npg}, 8'h01);
    chk("npr_lvl", 8'(grant_level), 8'd0);
    release_bus();
    cpu_prio = 3'd7; bus_npr = 1'b1; bus_br = 4'b1000;
    tick();
    chk("npr_p7", {bus_bg_out, 3'b0, bus_npg}, 8'h01);
    release_bus();
    bus_br = 4'b1000;
    tick(3);
    chk("p7_block", {bus_bg_out, 3'b0, cpu_hold}, 8'h00);
    cpu_prio = 3'd0; cpu_br_window = 1'b0;
    tick(3);
    chk("win_block", {bus_bg_out, 3'b0, cpu_hold}, 8'h00);
    cpu_br_window = 1'b1; cpu_prio = 3'd5; bus_br = 4'b0011;
    tick(4);
    chk("p5_block", {bus_bg_out, 3'b0, cpu_hold}, 8'h00);
    cpu_prio = 3'd3;
    tick();
    chk("br5_g", 8'(bus_bg_out), 8'h02);
    chk("br5_lvl", 8'(grant_level), 8'd5);
    cpu_prio = 3'd7; bus_br = 4'b1000;
    tick();
    chk("grant_stick", 8'(bus_bg_out), 8'h02);
    release_bus();
    cpu_prio = 3'd0; bus_br = 4'b0001;
    tick();
    chk("br4_g", 8'(bus_bg_out), 8'h01);
    hi = 1;
    for (int i = 0; i < 1000 && bus_bg_out != 0; i++) begin
      chk("ns_early", 8'(no_sack), 8'd0);
      tick();
      if (bus_bg_out != 0) hi++;
    end
    chk("to_len_lo", 8'(hi), 8'(500));
    chk("to_len_hi", 8'(hi >> 8), 8'(500 >> 8));
    chk("to_pulse", {bus_bg_out, 2'b0, cpu_hold, no_sack}, 8'h01);
    tick();
    chk("to_regrant", {bus_bg_out, 2'b0, cpu_hold, no_sack}, 8'h12);
    tick(499);
    chk("edge_held", 8'(bus_bg_out), 8'h01);
    bus_sack = 1'b1;
    tick();
    chk("edge_ack", {bus_bg_out, 2'b0, cpu_hold, no_sack}, 8'h02);
    bus_sack = 1'b0; bus_bbsy = 1'b1; bus_br = 4'b1000;
    tick(2);
    chk("edge_ns", 8'(no_sack), 8'd0);
    chk("stuck_bbsy", 8'(cpu_hold), 8'd1);
    bus_init = 1'b1;
    tick();
    chk("init_out", {bus_bg_out, bus_npg, cpu_hold, no_sack, 1'b0}, 8'h00);
    chk("init_lvl", 8'(grant_level), 8'd0);
    tick();
    chk("init_hold2", {bus_bg_out, 3'b0, cpu_hold}, 8'h00);
    bus_init = 1'b0;
    tick();
    chk("post_init", 8'(bus_bg_out), 8'h08);
    chk("post_lvl", 8'(grant_level), 8'd7);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
